// File: rtl/hub75_pkg.sv
// Shared constants and flush-FSM state type for the HUB75 capture path.
package hub75_pkg;

  localparam int ROW_W   = 4;
  localparam int PLANE_W = 2;
  localparam int RGB_W   = 6;

  // Bit positions inside panel_rgb / wr_data: {r0,r1,g0,g1,b0,b1}
  localparam int RGB_R0 = 5;
  localparam int RGB_R1 = 4;
  localparam int RGB_G0 = 3;
  localparam int RGB_G1 = 2;
  localparam int RGB_B0 = 1;
  localparam int RGB_B1 = 0;

  // Packed panel input word: {sclk, latch, pa[3:0], rgb[5:0]}
  localparam int IN_W     = 2 + ROW_W + RGB_W;
  localparam int IN_SCLK  = IN_W - 1;
  localparam int IN_LATCH = IN_W - 2;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } flush_state_e;

endpackage

// File: rtl/hub75_line_buf.sv
// Ping-pong line store: fill side written by panel shifts, flush side read by the
// write-out FSM. A swap exchanges the two sides.
module hub75_line_buf
  import hub75_pkg::*;
#(
  parameter int COLS = 64,
  localparam int AW  = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             swap_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [RGB_W-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [RGB_W-1:0] rd_data_o
);

  logic             sel_q;
  logic [RGB_W-1:0] bank0_q [COLS];
  logic [RGB_W-1:0] bank1_q [COLS];

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q <= 1'b0;
    end else if (swap_i) begin
      sel_q <= ~sel_q;
    end
  end

  // A shift coinciding with a swap still lands in the outgoing (old fill) bank.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      if (sel_q) begin
        bank1_q[wr_addr_i] <= wr_data_i;
      end else begin
        bank0_q[wr_addr_i] <= wr_data_i;
      end
    end
  end

  assign rd_data_o = sel_q ? bank0_q[rd_addr_i] : bank1_q[rd_addr_i];

endmodule

// File: rtl/hub75_capture.sv
// HUB75 receiver: samples panel lines on clk, rebuilds each shifted line and
// writes it out as {plane,row,col} pixel words. Define HUB75_CAPTURE_SYNC_EN to add
// a two-flop synchroniser ahead of the input stage for asynchronous sources.
//
//   state    | meaning
//   ---------+-----------------------------------------------
//   ST_IDLE  | waiting for a latch rise; shifts fill the buffer
//   ST_FLUSH | streaming COLS words of the latched line out
module hub75_capture
  import hub75_pkg::*;
#(
  parameter int COLS   = 64,
  parameter int ROWS   = 16,
  parameter int PLANES = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    panel_sclk,
  input  logic                    panel_latch,
  input  logic [ROW_W-1:0]        panel_pa,
  input  logic [RGB_W-1:0]        panel_rgb,
  output logic                    wr_en,
  output logic [PLANE_W-1:0]      wr_plane,
  output logic [ROW_W-1:0]        wr_row,
  output logic [$clog2(COLS)-1:0] wr_col,
  output logic [RGB_W-1:0]        wr_data,
  output logic                    frame_start,
  output logic                    err_short,
  output logic                    err_long,
  output logic                    err_overrun
);

  localparam int COL_W = $clog2(COLS);
  localparam int FC_W  = $clog2(COLS + 1);
  localparam logic [FC_W-1:0]    FILL_FULL = FC_W'(COLS);
  localparam logic [COL_W-1:0]   COL_LAST  = COL_W'(COLS - 1);
  localparam logic [PLANE_W-1:0] PLANE_MAX = PLANE_W'(PLANES - 1);

  if (ROWS > (1 << ROW_W) || PLANES > (1 << PLANE_W)) begin : g_param_check
    $error("hub75_capture: ROWS/PLANES exceed address field widths");
  end

  logic [IN_W-1:0] raw_in, stage_in, s1_q, s2_q;

  assign raw_in = {panel_sclk, panel_latch, panel_pa, panel_rgb};

`ifdef HUB75_CAPTURE_SYNC_EN
  logic [IN_W-1:0] meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= raw_in;
      sync_q <= meta_q;
    end
  end

  assign stage_in = sync_q;
`else
  assign stage_in = raw_in;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= stage_in;
      s2_q <= s1_q;
    end
  end

  logic             sclk_rise, latch_rise;
  logic [ROW_W-1:0] s2_pa;
  logic [RGB_W-1:0] s2_rgb;

  assign sclk_rise  = s1_q[IN_SCLK] & ~s2_q[IN_SCLK];
  assign latch_rise = s1_q[IN_LATCH] & ~s2_q[IN_LATCH];
  assign s2_pa      = s2_q[RGB_W +: ROW_W];
  assign s2_rgb     = s2_q[RGB_W-1:0];

  flush_state_e       state_q, state_d;
  logic [FC_W-1:0]    fill_cnt_q, fill_cnt_d, fill_eff;
  logic [COL_W-1:0]   col_q, col_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [PLANE_W-1:0] plane_q, plane_d;
  logic               first_q, first_d;
  logic               err_short_q, err_short_d;
  logic               err_long_q, err_long_d;
  logic               err_ovr_q, err_ovr_d;
  logic               wr_en_q, wr_en_d;
  logic [PLANE_W-1:0] wr_plane_q, wr_plane_d;
  logic [ROW_W-1:0]   wr_row_q, wr_row_d;
  logic [COL_W-1:0]   wr_col_q, wr_col_d;
  logic [RGB_W-1:0]   wr_data_q, wr_data_d;
  logic               frame_start_q, frame_start_d;
  logic               fill_full, shift_ok, swap;
  logic [RGB_W-1:0]   rd_data;

  assign fill_full = (fill_cnt_q == FILL_FULL);
  assign shift_ok  = sclk_rise & ~fill_full;
  assign fill_eff  = fill_cnt_q + FC_W'(shift_ok);

  hub75_line_buf #(.COLS(COLS)) u_line_buf (
    .clk       (clk),
    .rst       (rst),
    .swap_i    (swap),
    .wr_en_i   (shift_ok),
    .wr_addr_i (fill_cnt_q[COL_W-1:0]),
    .wr_data_i (s2_rgb),
    .rd_addr_i (col_q),
    .rd_data_o (rd_data)
  );

  always_comb begin
    state_d       = state_q;
    fill_cnt_d    = fill_cnt_q;
    col_d         = col_q;
    row_d         = row_q;
    plane_d       = plane_q;
    first_d       = first_q;
    err_short_d   = err_short_q;
    err_long_d    = err_long_q;
    err_ovr_d     = err_ovr_q;
    swap          = 1'b0;
    wr_en_d       = 1'b0;
    wr_plane_d    = '0;
    wr_row_d      = '0;
    wr_col_d      = '0;
    wr_data_d     = '0;
    frame_start_d = 1'b0;

    if (shift_ok) fill_cnt_d = fill_cnt_q + 1'b1;
    if (sclk_rise && fill_full) err_long_d = 1'b1;
    if (latch_rise) fill_cnt_d = '0;

    unique case (state_q)
      ST_IDLE: begin
        if (latch_rise) begin
          state_d = ST_FLUSH;
          swap    = 1'b1;
          col_d   = '0;
          row_d   = s2_pa;
          first_d = 1'b0;
          if (!first_q && s2_pa == row_q && plane_q < PLANE_MAX) begin
            plane_d = plane_q + 1'b1;
          end else begin
            plane_d = '0;
          end
          if (fill_eff < FILL_FULL) err_short_d = 1'b1;
        end
      end
      ST_FLUSH: begin
        // A latch here is dropped; only the error flag and fill count react.
        if (latch_rise) err_ovr_d = 1'b1;
        wr_en_d       = 1'b1;
        wr_plane_d    = plane_q;
        wr_row_d      = row_q;
        wr_col_d      = col_q;
        wr_data_d     = rd_data;
        frame_start_d = (col_q == '0) && (row_q == '0) && (plane_q == '0);
        if (col_q == COL_LAST) begin
          state_d = ST_IDLE;
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      fill_cnt_q    <= '0;
      col_q         <= '0;
      row_q         <= '0;
      plane_q       <= '0;
      first_q       <= 1'b1;
      err_short_q   <= 1'b0;
      err_long_q    <= 1'b0;
      err_ovr_q     <= 1'b0;
      wr_en_q       <= 1'b0;
      wr_plane_q    <= '0;
      wr_row_q      <= '0;
      wr_col_q      <= '0;
      wr_data_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      fill_cnt_q    <= fill_cnt_d;
      col_q         <= col_d;
      row_q         <= row_d;
      plane_q       <= plane_d;
      first_q       <= first_d;
      err_short_q   <= err_short_d;
      err_long_q    <= err_long_d;
      err_ovr_q     <= err_ovr_d;
      wr_en_q       <= wr_en_d;
      wr_plane_q    <= wr_plane_d;
      wr_row_q      <= wr_row_d;
      wr_col_q      <= wr_col_d;
      wr_data_q     <= wr_data_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_plane    = wr_plane_q;
  assign wr_row      = wr_row_q;
  assign wr_col      = wr_col_q;
  assign wr_data     = wr_data_q;
  assign frame_start = frame_start_q;
  assign err_short   = err_short_q;
  assign err_long    = err_long_q;
  assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_hub75_capture.sv
// Directed bench for hub75_capture: table of panel lines plus hand sequences for
// latency, overrun and reset during a flush.
module tb_hub75_capture;

  localparam int COLS = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       panel_sclk = 1'b0;
  logic       panel_latch = 1'b0;
  logic [3:0] panel_pa = '0;
  logic [5:0] panel_rgb = '0;
  logic       wr_en;
  logic [1:0] wr_plane;
  logic [3:0] wr_row;
  logic [5:0] wr_col;
  logic [5:0] wr_data;
  logic       frame_start, err_short, err_long, err_overrun;

  hub75_capture #(.COLS(COLS), .ROWS(16), .PLANES(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .panel_sclk  (panel_sclk),
    .panel_latch (panel_latch),
    .panel_pa    (panel_pa),
    .panel_rgb   (panel_rgb),
    .wr_en       (wr_en),
    .wr_plane    (wr_plane),
    .wr_row      (wr_row),
    .wr_col      (wr_col),
    .wr_data     (wr_data),
    .frame_start (frame_start),
    .err_short   (err_short),
    .err_long    (err_long),
    .err_overrun (err_overrun)
  );

  always #10 clk = ~clk;

  int tests = 0;
  int failed = 0;

  // Write monitor
  int         wcount = 0;
  int         fs_count = 0;
  int         bad_col = 0;
  int         exp_col = 0;
  logic [5:0] cap_data [COLS];
  logic [3:0] cap_row = '0;
  logic [1:0] cap_plane = '0;

  always @(negedge clk) begin
    if (rst) begin
      exp_col = 0;
    end else begin
      if (wr_en) begin
        cap_data[wr_col] = wr_data;
        cap_row   = wr_row;
        cap_plane = wr_plane;
        wcount++;
        if (int'(wr_col) != exp_col) bad_col++;
        exp_col = (exp_col + 1) % COLS;
      end
      if (frame_start) fs_count++;
    end
  end

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic do_shifts(input int n, input int seed);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      panel_rgb  = 6'((seed + i) % 64);
      panel_sclk = 1'b0;
      @(posedge clk); #1;
      panel_sclk = 1'b1;
    end
    @(posedge clk); #1;
    panel_sclk = 1'b0;
  endtask

  task automatic do_latch(input logic [3:0] row);
    @(posedge clk); #1;
    panel_pa = row;
    @(posedge clk); #1;
    panel_latch = 1'b1;
    @(posedge clk); #1;
    panel_latch = 1'b0;
  endtask

  task automatic apply_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  typedef struct {
    int         nshift;
    logic [3:0] row;
    int         seed;
    int         exp_plane;
    int         exp_fs;
    int         exp_short;
    int         exp_long;
  } vec_t;

  vec_t vecs [11];

  initial begin
    int w0, f0, b0, nbad, nchk;
    logic [5:0] e;

    vecs[0]  = '{64, 4'd3,  0,  0, 0, 0, 0};
    vecs[1]  = '{64, 4'd0,  5,  0, 1, 0, 0};
    vecs[2]  = '{64, 4'd5,  10, 0, 0, 0, 0};
    vecs[3]  = '{64, 4'd5,  20, 1, 0, 0, 0};
    vecs[4]  = '{64, 4'd5,  30, 2, 0, 0, 0};
    vecs[5]  = '{64, 4'd5,  40, 0, 0, 0, 0};
    vecs[6]  = '{64, 4'd15, 50, 0, 0, 0, 0};
    vecs[7]  = '{64, 4'd0,  60, 0, 1, 0, 0};
    vecs[8]  = '{64, 4'd0,  7,  1, 0, 0, 0};
    vecs[9]  = '{10, 4'd7,  13, 0, 0, 1, 0};
    vecs[10] = '{70, 4'd7,  33, 1, 0, 1, 1};

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_wr_en", int'(wr_en), 0);
    check("rst_fields", int'({wr_plane, wr_row, wr_col, wr_data}), 0);
    check("rst_frame_start", int'(frame_start), 0);
    check("rst_errs", int'({err_short, err_long, err_overrun}), 0);
    @(posedge clk); #1 rst = 1'b0;

    // Table-driven lines
    for (int v = 0; v < 11; v++) begin
      w0 = wcount; f0 = fs_count; b0 = bad_col;
      do_shifts(vecs[v].nshift, vecs[v].seed);
      do_latch(vecs[v].row);
      repeat (COLS + 6) @(posedge clk);
      @(negedge clk);
      check($sformatf("v%0d_writes", v), wcount - w0, COLS);
      check($sformatf("v%0d_col_order", v), bad_col - b0, 0);
      check($sformatf("v%0d_row", v), int'(cap_row), int'(vecs[v].row));
      check($sformatf("v%0d_plane", v), int'(cap_plane), vecs[v].exp_plane);
      check($sformatf("v%0d_frame_start", v), fs_count - f0, vecs[v].exp_fs);
      nbad = 0;
      nchk = (vecs[v].nshift < COLS) ? vecs[v].nshift : COLS;
      for (int c = 0; c < nchk; c++) begin
        e = 6'((vecs[v].seed + c) % 64);
        if (cap_data[c] !== e) nbad++;
      end
      check($sformatf("v%0d_data_bad", v), nbad, 0);
      check($sformatf("v%0d_err_short", v), int'(err_short), vecs[v].exp_short);
      check($sformatf("v%0d_err_long", v), int'(err_long), vecs[v].exp_long);
      check($sformatf("v%0d_err_overrun", v), int'(err_overrun), 0);
    end

    // Latch-to-first-write latency after a fresh reset
    apply_reset();
    @(negedge clk);
    check("rst2_errs", int'({err_short, err_long, err_overrun}), 0);
    w0 = wcount;
    do_shifts(COLS, 0);
    @(posedge clk); #1 panel_pa = 4'd9;
    @(posedge clk); #1 panel_latch = 1'b1;
    @(negedge clk);
    @(posedge clk); #1 panel_latch = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("lat_not_yet", int'(wr_en), 0);
    @(negedge clk);
    check("lat_first_wr", int'(wr_en), 1);
    check("lat_first_col", int'(wr_col), 0);
    repeat (COLS + 4) @(negedge clk);
    check("lat_writes", wcount - w0, COLS);
    check("lat_plane", int'(cap_plane), 0);

    // Overrun: second latch 20 clks into the flush of row 9 (plane 1)
    w0 = wcount;
    do_shifts(COLS, 3);
    do_latch(4'd9);
    repeat (17) @(posedge clk);
    do_latch(4'd9);
    repeat (COLS + 6) @(posedge clk);
    @(negedge clk);
    check("ovr_flag", int'(err_overrun), 1);
    check("ovr_writes", wcount - w0, COLS);
    check("ovr_plane", int'(cap_plane), 1);
    do_shifts(COLS, 8);
    do_latch(4'd9);
    repeat (COLS + 6) @(posedge clk);
    @(negedge clk);
    check("ovr_next_plane", int'(cap_plane), 2);
    check("ovr_next_data0", int'(cap_data[0]), 8);

    // Reset during a flush
    do_shifts(COLS, 0);
    do_latch(4'd4);
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("midrst_active", int'(wr_en), 1);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_wr_en", int'(wr_en), 0);
    check("midrst_fields", int'({wr_plane, wr_row, wr_col, wr_data, frame_start}), 0);
    check("midrst_errs", int'({err_short, err_long, err_overrun}), 0);
    w0 = wcount;
    @(posedge clk); #1 rst = 1'b0;
    repeat (COLS + 10) @(posedge clk);
    @(negedge clk);
    check("midrst_no_writes", wcount - w0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/hub75_capture.md
# hub75_capture

Receiving end of the HUB75-style matrix panel interface. Monitors the panel shift clock, latch, row-address and six colour lines, reassembles each shifted line, and writes it into a frame store as `{plane, row, col}` addressed pixel words. Used as a loopback checker behind our LED driver and as the front end for panel-chaining and capture. Runs on the system 50 MHz clock; the panel lines are sampled, never used as clocks.

## Interface
Parameters:
- `COLS`, default 64: shifts per line.
- `ROWS`, default 16: row addresses; the row address width is 4.
- `PLANES`, default 3: bit planes per row.

Ports:
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, synchronous, active-high.
- `panel_sclk`, input, 1: panel shift clock.
- `panel_latch`, input, 1: line latch.
- `panel_pa`, input, 4: row address, `{pa4..pa1}`.
- `panel_rgb`, input, 6: `{r0,r1,g0,g1,b0,b1}`.
- `wr_en`, output, 1: frame-store write strobe.
- `wr_plane`, output, 2: bit plane of the write.
- `wr_row`, output, 4: row of the write.
- `wr_col`, output, $clog2(COLS): column of the write.
- `wr_data`, output, 6: pixel bits, ordered as `panel_rgb`.
- `frame_start`, output, 1: one-cycle pulse coincident with the first write of row 0, plane 0.
- `err_short`, output, 1: sticky; a latch arrived after fewer than COLS shifts.
- `err_long`, output, 1: sticky; more than COLS shifts arrived before a latch.
- `err_overrun`, output, 1: sticky; a latch arrived while the previous flush was still in progress.

## Operation
- **Input stage.** Every panel input is registered once (stage s1). Rising edges are detected from s1 against a second register (s2).
- **Shift capture.**
  - Each sclk rise writes the s2 `panel_rgb` value, i.e. the data one clk before the rise, into the fill buffer at index `fill_cnt`, then increments `fill_cnt`.
  - Once `fill_cnt == COLS`, further rises are dropped and `err_long` is set.
- **Latch handling.** A latch rise does all of the following in the same cycle:
  - Captures s2 `panel_pa` as the line's row.
  - Computes the plane:
    - 0 for the first latch after reset;
    - otherwise `plane+1` if the row equals the previous latched row and `plane < PLANES-1`;
    - otherwise 0.
  - Sets `err_short` if `fill_cnt < COLS`. The line is still flushed; unfilled entries hold stale data.
  - Swaps the ping-pong buffers, clears `fill_cnt`, and starts a flush.
- **Flush FSM.**
  - IDLE: waits for a latch rise.
  - FLUSH: issues COLS writes, one per cycle, with `wr_col` counting 0..COLS-1; returns to IDLE after the last write.
- **Overrun.** A latch rise while in FLUSH sets `err_overrun` and discards the new line: no swap, no plane or row update, `fill_cnt` cleared. The current flush continues.
- **Simultaneous sclk and latch rise.** The shift is applied to the outgoing line before the swap.
- **Wrap-around.** Row 15 followed by row 0 yields plane 0. No other frame tracking.
- **Reset values.**
  - All outputs are 0.
  - FSM is in IDLE.
  - `fill_cnt`, `plane` and the previous-row register are 0, with a first-latch flag set.
  - Buffer contents are don't-care.
- **Reset mid-flush.** The flush is abandoned immediately and no further `wr_en` is issued.

## Timing
- **Latch to first write.** A latch rise seen in s1 at cycle T puts the first `wr_en` (col 0) at T+2. The last write is at T+COLS+1.
- **Write outputs.** All write fields are registered and valid only while `wr_en` is high.
- **`frame_start`.** Asserted only in the col-0 write cycle of row 0, plane 0.
- **Throughput.** The driver produces at least 2·COLS+2 clks between latches. A flush of COLS cycles therefore never overruns a conforming source.
- **Error flags.** Assert the cycle after the causing edge and clear only on `rst`.

## Configuration
- `HUB75_CAPTURE_SYNC_EN` defined: two extra flops precede s1 on every input, for asynchronous sources. All latencies increase by 2.
- Not defined: single registration only; the source must share `clk`.

## Structure
- **Shared package `hub75_pkg`:**
  - `ROW_W = 4`, `PLANE_W = 2`, `RGB_W = 6`.
  - RGB bit-index constants.
  - The flush FSM state enum.
- **Sub-module `hub75_line_buf`:** two COLS×6 arrays with a ping-pong select, one write port (fill side) and one read port (flush side).

## Test plan
- **Full frame.** Drive 16 rows × 3 planes with pixel = col[5:0], via the real LED driver in loopback. Expect 3072 writes with every `{plane,row,col}` visited once, and `frame_start` once per frame at row 0, plane 0, col 0. No error flags set.
- **Short line.** 10 sclk rises, then a latch. Expect `err_short = 1` and 64 writes still issued.
- **Long line.** 70 sclk rises, then a latch. Expect `err_long = 1` and entries 0..63 equal to the first 64 shifts.
- **Overrun.** A second latch 20 clks after the first. Expect `err_overrun = 1`, exactly 64 writes, and the plane unchanged.
- **Reset mid-flush.** `rst` 10 clks into a flush. Expect `wr_en` low from the next cycle and all outputs 0.
- **Row repeat.** Latch row 5 four times. Expect planes 0, 1, 2, then 0.
